csr_file: RTL

Machine-mode control and status register file for the RV32I core. It serves two ports. The instruction port carries CSRRW/CSRRS/CSRRC from the execute stage. The trap port is driven by the trap controller for mepc/mcause writes and mtvec/mepc reads. It also maintains the 64-bit mcycle/minstret counters. It sits between the execute stage and the trap controller and is the sole owner of architectural CSR state.

---
 rtl/csr_file.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/csr_file.sv
// ============================================================================
//  Module   : csr_file
//  Purpose  : Machine-mode CSR file for the RV32I core with mcycle/minstret.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module csr_file #(
    parameter logic [31:0] HART_ID    = 32'd0,
    parameter logic [31:0] MISA_VALUE = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_enable,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_address,
    input  logic [31:0] csr_write_operand,
    input  logic        instret_pulse,
    input  logic        trap_active,
    input  logic        trap_write,
    input  logic [11:0] csr_trap_address,
    input  logic [31:0] csr_trap_write_data,
    output logic [31:0] csr_read_data,
    output logic        csr_illegal
);

    localparam logic [1:0]  c_OP_RW        = 2'b01;
    localparam logic [1:0]  c_OP_RS        = 2'b10;
    localparam logic [1:0]  c_OP_RC        = 2'b11;

    localparam logic [11:0] c_ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] c_ADDR_MISA     = 12'h301;
    localparam logic [11:0] c_ADDR_MIE      = 12'h304;
    localparam logic [11:0] c_ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] c_ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] c_ADDR_MEPC     = 12'h341;
    localparam logic [11:0] c_ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] c_ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] c_ADDR_MIP      = 12'h344;
    localparam logic [11:0] c_ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] c_ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] c_ADDR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] c_ADDR_MINSTRETH= 12'hB82;
    localparam logic [11:0] c_ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] c_ADDR_INSTRET  = 12'hC02;
    localparam logic [11:0] c_ADDR_CYCLEH   = 12'hC80;
    localparam logic [11:0] c_ADDR_INSTRETH = 12'hC82;
    localparam logic [11:0] c_ADDR_MVENDOR  = 12'hF11;
    localparam logic [11:0] c_ADDR_MARCH    = 12'hF12;
    localparam logic [11:0] c_ADDR_MIMP     = 12'hF13;
    localparam logic [11:0] c_ADDR_MHARTID  = 12'hF14;

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic [11:0] w_sel_addr;
    logic [31:0] w_rdata;
    logic        w_implemented;
    logic        w_read_only;
    logic        w_illegal;
    logic [31:0] w_wdata;
    logic        w_inst_we;
    logic        w_trap_we;

    assign w_sel_addr = trap_active ? csr_trap_address : csr_address;

    // Read mux also classifies the selected address for the illegal check.
    always_comb begin
        w_rdata       = 32'd0;
        w_implemented = 1'b1;
        w_read_only   = 1'b0;
        case (w_sel_addr)
            c_ADDR_MSTATUS:   w_rdata = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
            c_ADDR_MISA: begin
                w_rdata     = MISA_VALUE;
                w_read_only = 1'b1;
            end
            c_ADDR_MIE:       w_rdata = mie_q;
            c_ADDR_MTVEC:     w_rdata = mtvec_q;
            c_ADDR_MSCRATCH:  w_rdata = mscratch_q;
            c_ADDR_MEPC:      w_rdata = mepc_q;
            c_ADDR_MCAUSE:    w_rdata = mcause_q;
            c_ADDR_MTVAL:     w_rdata = mtval_q;
            c_ADDR_MIP:       w_rdata = 32'd0;
            c_ADDR_MCYCLE:    w_rdata = mcycle_q[31:0];
            c_ADDR_MCYCLEH:   w_rdata = mcycle_q[63:32];
            c_ADDR_MINSTRET:  w_rdata = minstret_q[31:0];
            c_ADDR_MINSTRETH: w_rdata = minstret_q[63:32];
            c_ADDR_CYCLE: begin
                w_rdata     = mcycle_q[31:0];
                w_read_only = 1'b1;
            end
            c_ADDR_CYCLEH: begin
                w_rdata     = mcycle_q[63:32];
                w_read_only = 1'b1;
            end
            c_ADDR_INSTRET: begin
                w_rdata     = minstret_q[31:0];
                w_read_only = 1'b1;
            end
            c_ADDR_INSTRETH: begin
                w_rdata     = minstret_q[63:32];
                w_read_only = 1'b1;
            end
            c_ADDR_MVENDOR, c_ADDR_MARCH, c_ADDR_MIMP: begin
                w_rdata     = 32'd0;
                w_read_only = 1'b1;
            end
            c_ADDR_MHARTID: begin
                w_rdata     = HART_ID;
                w_read_only = 1'b1;
            end
            default: w_implemented = 1'b0;
        endcase
    end

    // Read-only CSRs tolerate RS/RC with a zero operand (pure reads).
    assign w_illegal = csr_enable && !trap_active &&
                       (!w_implemented ||
                        (w_read_only && ((csr_op == c_OP_RW) ||
                                         (csr_op[1] && (csr_write_operand != 32'd0)))));

    always_comb begin
        case (csr_op)
            c_OP_RW: w_wdata = csr_write_operand;
            c_OP_RS: w_wdata = w_rdata | csr_write_operand;
            c_OP_RC: w_wdata = w_rdata & ~csr_write_operand;
            default: w_wdata = w_rdata;
        endcase
    end

    assign w_inst_we = csr_enable && !trap_active && !trap_write && !w_illegal &&
                       (csr_op != 2'b00);
    assign w_trap_we = trap_write &&
                       ((csr_trap_address == c_ADDR_MEPC) ||
                        (csr_trap_address == c_ADDR_MCAUSE) ||
                        (csr_trap_address == c_ADDR_MTVAL));

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mcycle_d       = mcycle_q + 64'd1;
        minstret_d     = minstret_q + {63'd0, instret_pulse};

        if (w_inst_we) begin
            case (csr_address)
                c_ADDR_MSTATUS: begin
                    mstatus_mie_d  = w_wdata[3];
                    mstatus_mpie_d = w_wdata[7];
                end
                c_ADDR_MIE:       mie_d      = w_wdata;
                c_ADDR_MTVEC:     mtvec_d    = {w_wdata[31:2], 2'b00};
                c_ADDR_MSCRATCH:  mscratch_d = w_wdata;
                c_ADDR_MEPC:      mepc_d     = {w_wdata[31:2], 2'b00};
                c_ADDR_MCAUSE:    mcause_d   = w_wdata;
                c_ADDR_MTVAL:     mtval_d    = w_wdata;
                c_ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], w_wdata};
                c_ADDR_MCYCLEH:   mcycle_d   = {w_wdata, mcycle_q[31:0]};
                c_ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], w_wdata};
                c_ADDR_MINSTRETH: minstret_d = {w_wdata, minstret_q[31:0]};
                default: ;
            endcase
        end

        if (w_trap_we) begin
            case (csr_trap_address)
                c_ADDR_MEPC:   mepc_d   = {csr_trap_write_data[31:2], 2'b00};
                c_ADDR_MCAUSE: mcause_d = csr_trap_write_data;
                c_ADDR_MTVAL:  mtval_d  = csr_trap_write_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 32'd0;
            mtvec_q        <= 32'd0;
            mscratch_q     <= 32'd0;
            mepc_q         <= 32'd0;
            mcause_q       <= 32'd0;
            mtval_q        <= 32'd0;
            mcycle_q       <= 64'd0;
            minstret_q     <= 64'd0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

    assign csr_read_data = w_rdata;
    assign csr_illegal   = w_illegal;

endmodule

`default_nettype wire
